// File: rtl/extmem_responder.sv
// Word-addressed 1R1W external-memory responder: zero-fill init FSM, range guard, activity counters.
// Optional per-word even parity is enabled with `define EXTMEM_PARITY_EN.
module extmem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clear_req_i,
  output logic              init_done_o,
  output logic              err_oob_o,
  output logic [CNT_W-1:0]  oob_count_o,
  output logic [CNT_W-1:0]  rd_count_o,
`ifdef EXTMEM_PARITY_EN
  output logic              par_err_o,
  output logic [CNT_W-1:0]  par_count_o,
`endif
  output logic [CNT_W-1:0]  wr_count_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
`ifdef EXTMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  fill_ptr_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              init_done_q, err_oob_q;
  logic [CNT_W-1:0]  oob_count_q, rd_count_q, wr_count_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic             ready, rd_ok, wr_ok, rd_rej, wr_rej, bypass;
  logic [IDX_W-1:0] rd_idx, wr_idx, mem_widx;
  logic [MEM_W-1:0] mem_wword, rd_word;
  logic             mem_we;

  assign ready  = (state_q == S_READY);
  assign rd_idx = rd_addr_i[IDX_W-1:0];
  assign wr_idx = wr_addr_i[IDX_W-1:0];
  // An address is in range when nothing is set above the index bits.
  assign rd_ok  = re_i && ready && ((rd_addr_i >> IDX_W) == '0);
  assign wr_ok  = we_i && ready && ((wr_addr_i >> IDX_W) == '0);
  assign rd_rej = re_i && !rd_ok;
  assign wr_rej = we_i && !wr_ok;
  assign bypass = wr_ok && (wr_idx == rd_idx);
  assign rd_word = mem_q[rd_idx];

  // The single write port is owned by the zero-fill while not ready.
  always_comb begin
    mem_we   = wr_ok;
    mem_widx = wr_idx;
`ifdef EXTMEM_PARITY_EN
    mem_wword = {^wr_data_i, wr_data_i};
`else
    mem_wword = wr_data_i;
`endif
    if (!ready) begin
      mem_we    = 1'b1;
      mem_widx  = fill_ptr_q;
      mem_wword = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wword;
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_ok) rd_data_d = bypass ? wr_data_i : rd_word[DATA_W-1:0];
  end

`ifdef EXTMEM_PARITY_EN
  logic             par_err_q, par_bad;
  logic [CNT_W-1:0] par_count_q;
  assign par_bad = rd_ok && !bypass && (^rd_word);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q   <= 1'b0;
      par_count_q <= '0;
    end else begin
      if (par_bad) par_err_q <= 1'b1;
      par_count_q <= sat_add(par_count_q, {1'b0, par_bad});
    end
  end
  assign par_err_o   = par_err_q;
  assign par_count_o = par_count_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      fill_ptr_q  <= '0;
      init_done_q <= 1'b0;
      err_oob_q   <= 1'b0;
      rd_data_q   <= '0;
      oob_count_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (clear_req_i) begin
            fill_ptr_q <= '0;
          end else if (fill_ptr_q == LAST) begin
            state_q     <= S_READY;
            init_done_q <= 1'b1;
            fill_ptr_q  <= '0;
          end else begin
            fill_ptr_q <= fill_ptr_q + 1'b1;
          end
        end
        default: begin
          if (clear_req_i) begin
            state_q     <= S_INIT;
            fill_ptr_q  <= '0;
            init_done_q <= 1'b0;
          end
        end
      endcase
      if (re_i) rd_data_q <= rd_data_d;
      if (rd_rej || wr_rej) err_oob_q <= 1'b1;
      oob_count_q <= sat_add(oob_count_q, {1'b0, rd_rej} + {1'b0, wr_rej});
      rd_count_q  <= sat_add(rd_count_q, {1'b0, rd_ok});
      wr_count_q  <= sat_add(wr_count_q, {1'b0, wr_ok});
    end
  end

  assign rd_data_o   = rd_data_q;
  assign init_done_o = init_done_q;
  assign err_oob_o   = err_oob_q;
  assign oob_count_o = oob_count_q;
  assign rd_count_o  = rd_count_q;
  assign wr_count_o  = wr_count_q;
endmodule

// File: tb/tb_extmem_responder.sv
// Scoreboard bench for extmem_responder: stimulus pushes expected read data, a monitor pops and checks.
module tb_extmem_responder;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              re, we, clear_req;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              init_done, err_oob;
  logic [CNT_W-1:0]  oob_count, rd_count, wr_count;
`ifdef EXTMEM_PARITY_EN
  logic              par_err;
  logic [CNT_W-1:0]  par_count;
`endif

  extmem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .re_i(re), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clear_req_i(clear_req), .init_done_o(init_done), .err_oob_o(err_oob),
    .oob_count_o(oob_count), .rd_count_o(rd_count),
`ifdef EXTMEM_PARITY_EN
    .par_err_o(par_err), .par_count_o(par_count),
`endif
    .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              re_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read issued at edge N is checked mid-cycle after edge N+1.
  always @(posedge clk) re_seen <= re && !rst;
  always @(negedge clk) begin
    if (re_seen) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_data: unexpected read response 0x%0h at %0t", rd_data, $time);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input bit r, input int ra, input bit w, input int wa,
                       input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] e);
    re = r; rd_addr = ADDR_W'(ra);
    we = w; wr_addr = ADDR_W'(wa); wr_data = wd;
    if (r) exp_q.push_back(e);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    drive(1'b0, 0, 1'b1, a, d, '0);
  endtask

  task automatic rd(input int a, input logic [DATA_W-1:0] e);
    drive(1'b1, a, 1'b0, 0, '0, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 4*DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int cyc;

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; clear_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    idle(3);
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset init_done", 32'(init_done), 0);
    chk("reset err_oob", 32'(err_oob), 0);
    chk("reset oob_count", oob_count, 0);
    chk("reset rd_count", rd_count, 0);
    chk("reset wr_count", wr_count, 0);
    rst = 1'b0;
    wait_init(cyc);
    chk("init latency", cyc, DEPTH);

    for (int i = 0; i < 4; i++) rd(i, 16'h0000);
    idle(1);
    chk("rd_count after 4 reads", rd_count, 4);

    wr(10, 16'hA5A5);
    rd(10, 16'hA5A5);

    for (int i = 0; i < 8; i++) wr(20 + i, 16'h0100 + 16'(i));
    for (int i = 0; i < 8; i++) rd(20 + i, 16'h0100 + 16'(i));

    drive(1'b1, 5, 1'b1, 5, 16'h1234, 16'h1234);
    rd(5, 16'h1234);

    wr(7, 16'h0777);
    drive(1'b1, DEPTH, 1'b1, DEPTH + 7, 16'hDEAD, 16'h0000);
    idle(1);
    chk("oob_count after double reject", oob_count, 2);
    chk("err_oob after reject", 32'(err_oob), 1);
    rd(7, 16'h0777);
    idle(2);
    chk("rd_data hold", 32'(rd_data), 32'h0777);

    wr(3, 16'hFFFF);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    chk("init_done drops after clear", 32'(init_done), 0);
    rd(3, 16'h0000);
    idle(1);
    chk("oob_count after init-time read", oob_count, 3);
    chk("rd_count total", rd_count, 16);
    chk("wr_count total", wr_count, 12);
    wait_init(cyc);
    chk("re-init latency", cyc, DEPTH - 2);
    chk("err_oob survives clear", 32'(err_oob), 1);
    rd(3, 16'h0000);
    rd(10, 16'h0000);

`ifdef EXTMEM_PARITY_EN
    wr(9, 16'h1234);
    dut.mem_q[9][DATA_W] = ~dut.mem_q[9][DATA_W];
    rd(9, 16'h1234);
    idle(1);
    chk("par_err", 32'(par_err), 1);
    chk("par_count", par_count, 1);
`endif

    idle(3);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
